alu_sched: RTL

Round-robin scheduler sharing the single 18-bit registered adder ALU among `NREQ` requesters. It accepts operand pairs through valid/ready handshakes and drives the ALU operand inputs from a register stage. It captures the ALU sum, computes signed-overflow and zero flags, and returns tagged results through a backpressured result FIFO. It sits between the requesting datapath units and the ALU instance.

---
 rtl/alu_sched_if.sv | 31 +++
 rtl/alu_sched.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/alu_sched_if.sv
// alu_sched_if: requester operand handshake and tagged result handshake.
// master = requesters/consumer side, slave = scheduler side.
interface alu_sched_if #(
   parameter int NREQ = 4,
   parameter int W    = 18
);
   localparam int IW = $clog2(NREQ);

   logic [NREQ-1:0]   req_valid;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic [NREQ-1:0]   req_ready;
   logic              res_valid;
   logic              res_ready;
   logic [IW-1:0]     res_id;
   logic [W-1:0]      res_data;
   logic              res_ovf;
   logic              res_zero;

   modport master (
      output req_valid, req_a, req_b, res_ready,
      input  req_ready, res_valid, res_id,
      input  res_data, res_ovf, res_zero
   );

   modport slave (
      input  req_valid, req_a, req_b, res_ready,
      output req_ready, res_valid, res_id,
      output res_data, res_ovf, res_zero
   );
endinterface

// File: rtl/alu_sched.sv
// alu_sched: round-robin sharing of one registered adder ALU.
// Ports: clk, rst_n, bus (req/res handshakes), alu_a/alu_b/alu_out, busy.
module alu_sched #(
   parameter int NREQ  = 4,
   parameter int W     = 18,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   alu_sched_if.slave   bus,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   input  logic [W-1:0] alu_out,
   output logic         busy
);
   localparam int IW = $clog2(NREQ);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int EW = IW + W + 2;

   logic [IW-1:0] ptr_q, ptr_d;
   logic [W-1:0]  alu_a_q, alu_a_d;
   logic [W-1:0]  alu_b_q, alu_b_d;
   logic          s1_v_q, s1_v_d, s2_v_q;
   logic [IW-1:0] s1_id_q, s1_id_d, s2_id_q;
   logic          s1_sa_q, s1_sa_d, s2_sa_q;
   logic          s1_sb_q, s1_sb_d, s2_sb_q;
   logic [EW-1:0] mem_q [DEPTH];
   logic [EW-1:0] mem_d [DEPTH];
   logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [W-1:0]  a_arr [NREQ];
   logic [W-1:0]  b_arr [NREQ];
   logic          gnt_found;
   logic [IW-1:0] gnt_idx;
   logic [IW-1:0] scan;
   logic [CW:0]   inflight;
   logic          issue_ok, fire, push, pop;
   logic          ovf, zero;
   logic [EW-1:0] head;

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         a_arr[i] = bus.req_a[i*W +: W];
         b_arr[i] = bus.req_b[i*W +: W];
      end
   end

   // first valid requester scanning from ptr
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      scan      = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan = IW'((int'(ptr_q) + k) % NREQ);
         if (!gnt_found && bus.req_valid[scan]) begin
            gnt_found = 1'b1;
            gnt_idx   = scan;
         end
      end
   end

   // credit uses registered occupancy only; a pop this cycle gives no credit
   always_comb begin
      inflight = {1'b0, cnt_q}
               + {{CW{1'b0}}, s1_v_q}
               + {{CW{1'b0}}, s2_v_q};
      issue_ok = rst_n & (inflight < (CW+1)'(DEPTH));
      fire     = issue_ok & gnt_found;
      bus.req_ready = '0;
      if (fire) bus.req_ready[gnt_idx] = 1'b1;
   end

   always_comb begin
      ptr_d   = ptr_q;
      alu_a_d = alu_a_q;
      alu_b_d = alu_b_q;
      s1_v_d  = fire;
      s1_id_d = gnt_idx;
      s1_sa_d = a_arr[gnt_idx][W-1];
      s1_sb_d = b_arr[gnt_idx][W-1];
      if (fire) begin
         alu_a_d = a_arr[gnt_idx];
         alu_b_d = b_arr[gnt_idx];
         if (gnt_idx == IW'(NREQ - 1)) ptr_d = '0;
         else                          ptr_d = gnt_idx + 1'b1;
      end
   end

   always_comb begin
      ovf  = (s2_sa_q == s2_sb_q) & (alu_out[W-1] != s2_sa_q);
      zero = ~|alu_out;
      push = s2_v_q;
      pop  = (cnt_q != '0) & bus.res_ready;
      mem_d = mem_q;
      if (push) mem_d[wp_q] = {s2_id_q, alu_out, ovf, zero};
      wp_d = wp_q;
      rp_d = rp_q;
      if (push) wp_d = (wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + 1'b1;
      if (pop)  rp_d = (rp_q == PW'(DEPTH - 1)) ? '0 : rp_q + 1'b1;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q   <= '0;
         alu_a_q <= '0;
         alu_b_q <= '0;
         s1_v_q  <= 1'b0;
         s1_id_q <= '0;
         s1_sa_q <= 1'b0;
         s1_sb_q <= 1'b0;
         s2_v_q  <= 1'b0;
         s2_id_q <= '0;
         s2_sa_q <= 1'b0;
         s2_sb_q <= 1'b0;
         wp_q    <= '0;
         rp_q    <= '0;
         cnt_q   <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         ptr_q   <= ptr_d;
         alu_a_q <= alu_a_d;
         alu_b_q <= alu_b_d;
         s1_v_q  <= s1_v_d;
         s1_id_q <= s1_id_d;
         s1_sa_q <= s1_sa_d;
         s1_sb_q <= s1_sb_d;
         s2_v_q  <= s1_v_q;
         s2_id_q <= s1_id_q;
         s2_sa_q <= s1_sa_q;
         s2_sb_q <= s1_sb_q;
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         cnt_q   <= cnt_d;
         mem_q   <= mem_d;
      end
   end

   assign head  = (cnt_q != '0) ? mem_q[rp_q] : '0;
   assign alu_a = alu_a_q;
   assign alu_b = alu_b_q;
   assign busy  = s1_v_q | s2_v_q | (cnt_q != '0);

   assign bus.res_valid = (cnt_q != '0);
   assign {bus.res_id, bus.res_data, bus.res_ovf, bus.res_zero} = head;
endmodule
